rfft_loader: RTL

- Upstream feeder for the 256-point radix-2 FFT core. Accepts one real sample per cycle on a valid/ready stream and reorders each 256-sample frame into the core's four-bank layout: sample n goes to bank n[7:6] at address n[5:0].
- Drives the core's load port (Addr/Input/Write/Din0-3), then releases it to compute and waits for done.
- Afterwards, hands the core's result port to a downstream reader until that reader releases it.

---
 rtl/rfft_loader_if.sv | 30 +++
 rtl/rfft_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/rfft_loader_if.sv
// Bundle of the sample stream, FFT-core load port and result-reader handshake for rfft_loader.
interface rfft_loader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             fft_done;
    logic [5:0]       Addr;
    logic             Input;
    logic             Write;
    logic [WIDTH-1:0] Din0;
    logic [WIDTH-1:0] Din1;
    logic [WIDTH-1:0] Din2;
    logic [WIDTH-1:0] Din3;
    logic [5:0]       rd_addr;
    logic             rd_release;
    logic             result_valid;
    logic             busy;

    modport slave (
        input  in_data, in_valid, fft_done, rd_addr, rd_release,
        output in_ready, Addr, Input, Write, Din0, Din1, Din2, Din3, result_valid, busy
    );

    modport master (
        output in_data, in_valid, fft_done, rd_addr, rd_release,
        input  in_ready, Addr, Input, Write, Din0, Din1, Din2, Din3, result_valid, busy
    );
endinterface

// File: rtl/rfft_loader.sv
// Reorders a 256-sample real stream into the FFT core's four-bank layout, then sequences
// the core through compute and hands its result port to a downstream reader.
module rfft_loader #(
    parameter int WIDTH   = 32,
    parameter int FRAME   = 256,
    parameter int QUARTER = 64
) (
    input  logic         Clk,
    input  logic         Reset,
    rfft_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_BURST  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [7:0] FILL_LAST  = 8'(3 * QUARTER - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAME - 1);

    logic [2:0]       state;
    logic [7:0]       n;
    logic [WIDTH-1:0] q0 [QUARTER];
    logic [WIDTH-1:0] q1 [QUARTER];
    logic [WIDTH-1:0] q2 [QUARTER];
    logic             accept;
    logic [5:0]       addr_r;
    logic             write_r;
    logic             input_r;
    logic [WIDTH-1:0] d0, d1, d2, d3;

    assign bus.in_ready     = (state == S_IDLE) || (state == S_FILL) || (state == S_BURST);
    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.result_valid = (state == S_RESULT);
    assign bus.busy         = (state != S_IDLE);
    assign bus.Addr         = bus.result_valid ? bus.rd_addr : addr_r;
    assign bus.Input        = input_r;
    assign bus.Write        = write_r;
    assign bus.Din0         = d0;
    assign bus.Din1         = d1;
    assign bus.Din2         = d2;
    assign bus.Din3         = d3;

    // The last quarter is never staged: it goes straight to Din3 alongside the staged rows.
    always_ff @(posedge Clk) begin
        if (accept && n[7:6] != 2'd3) begin
            if (n[7:6] == 2'd0)      q0[n[5:0]] <= bus.in_data;
            else if (n[7:6] == 2'd1) q1[n[5:0]] <= bus.in_data;
            else                     q2[n[5:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            n       <= '0;
            addr_r  <= '0;
            write_r <= 1'b0;
            input_r <= 1'b1;
            d0      <= '0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
        end else begin
            write_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        n     <= n + 8'd1;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        n <= n + 8'd1;
                        if (n == FILL_LAST) state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (accept) begin
                        write_r <= 1'b1;
                        addr_r  <= n[5:0];
                        d0      <= q0[n[5:0]];
                        d1      <= q1[n[5:0]];
                        d2      <= q2[n[5:0]];
                        d3      <= bus.in_data;
                        // n holds at the last index until the reader releases the frame
                        if (n == FRAME_LAST) state <= S_RUN;
                        else                 n     <= n + 8'd1;
                    end
                end
                S_RUN: begin
                    // First RUN cycle still carries the final write, so done is not yet trusted.
                    if (input_r) begin
                        input_r <= 1'b0;
                        addr_r  <= '0;
                    end else if (bus.fft_done) begin
                        input_r <= 1'b1;
                        state   <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (bus.rd_release) begin
                        n     <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
